// File: rtl/apb_cmd_master_if.sv
// Command, response and APB4 requester signals of apb_cmd_master in one bundle.
// Latency: none, wires only.
// Backpressure: carried by cmd_ready / rsp_ready / m_apb_pready.
interface apb_cmd_master_if #(
    parameter int unsigned G_ADDR_WIDTH = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [G_ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]             cmd_wdata;
    logic [3:0]              cmd_strb;
    logic [2:0]              cmd_prot;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic                    m_apb_psel;
    logic                    m_apb_penable;
    logic                    m_apb_pwrite;
    logic [2:0]              m_apb_pprot;
    logic [G_ADDR_WIDTH-1:0] m_apb_paddr;
    logic [31:0]             m_apb_pwdata;
    logic [3:0]              m_apb_pstrb;
    logic                    m_apb_pready;
    logic [31:0]             m_apb_prdata;
    logic                    m_apb_pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pprot,
        output m_apb_paddr, m_apb_pwdata, m_apb_pstrb,
        input  m_apb_pready, m_apb_prdata, m_apb_pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pprot,
        input  m_apb_paddr, m_apb_pwdata, m_apb_pstrb,
        output m_apb_pready, m_apb_prdata, m_apb_pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 requester: one setup/access transfer per command, response with rdata/err/timeout.
// Latency: accept edge T0 -> psel T0+, penable T1+, rsp_valid T2+ plus one cycle per wait state.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready; wait states bounded by G_TIMEOUT.
module apb_cmd_master #(
    parameter int unsigned G_ADDR_WIDTH = 4,
    parameter int unsigned G_TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    apb_cmd_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0]              TMO_LIMIT = 8'(G_TIMEOUT);
    localparam bit                      TMO_EN    = (G_TIMEOUT != 0);
    localparam logic [G_ADDR_WIDTH-1:0] LSB_MASK  = G_ADDR_WIDTH'(3);

    state_t state, next_state;
    logic   accept, complete, expire;

    logic                    cmd_ready_q;
    logic                    psel_q, penable_q, pwrite_q;
    logic [2:0]              pprot_q;
    logic [G_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]             pwdata_q;
    logic [3:0]              pstrb_q;
    logic [7:0]              wait_cnt, cnt_inc;

    logic        rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [31:0] rsp_rdata_q;

    // Count of ACCESS cycles including the current one, saturating at 255.
    assign cnt_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: next_state = ACCESS;
            ACCESS: begin
                // pready beats the timeout when both land on the same cycle.
                if (bus.m_apb_pready) begin
                    complete   = 1'b1;
                    next_state = RESP;
                end else if (TMO_EN && (cnt_inc == TMO_LIMIT)) begin
                    expire     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Every output is a flop loaded from next_state, so reset drives them all to 0
    // and cmd_ready only rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pprot_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            wait_cnt      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            cmd_ready_q <= (next_state == IDLE);
            psel_q      <= (next_state == SETUP) || (next_state == ACCESS);
            penable_q   <= (next_state == ACCESS);
            rsp_valid_q <= (next_state == RESP);

            if (accept) begin
                paddr_q  <= bus.cmd_addr & ~LSB_MASK;
                pwrite_q <= bus.cmd_write;
                pwdata_q <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : 4'd0;
                pprot_q  <= bus.cmd_prot;
                wait_cnt <= '0;
            end else if (complete || expire) begin
                paddr_q  <= '0;
                pwrite_q <= 1'b0;
                pwdata_q <= '0;
                pstrb_q  <= '0;
                pprot_q  <= '0;
            end else if (state == ACCESS) begin
                wait_cnt <= cnt_inc;
            end

            if (complete) begin
                rsp_rdata_q   <= pwrite_q ? 32'd0 : bus.m_apb_prdata;
                rsp_err_q     <= bus.m_apb_pslverr;
                rsp_timeout_q <= 1'b0;
            end else if (expire) begin
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end else if ((state == RESP) && bus.rsp_ready) begin
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b0;
                rsp_timeout_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.m_apb_psel    = psel_q;
    assign bus.m_apb_penable = penable_q;
    assign bus.m_apb_pwrite  = pwrite_q;
    assign bus.m_apb_pprot   = pprot_q;
    assign bus.m_apb_paddr   = paddr_q;
    assign bus.m_apb_pwdata  = pwdata_q;
    assign bus.m_apb_pstrb   = pstrb_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed and randomized bench for apb_cmd_master; the bench itself plays the APB slave.
// Expected APB payload, response and cycle counts come from a transaction-level model.
module tb_apb_cmd_master;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    apb_cmd_master_if #(.G_ADDR_WIDTH(4)) bus ();

    apb_cmd_master #(.G_ADDR_WIDTH(4), .G_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_apb(input string tag);
        chk1({tag, "_psel"}, bus.m_apb_psel, 1'b0);
        chk1({tag, "_penable"}, bus.m_apb_penable, 1'b0);
        chk({tag, "_payload"}, {bus.m_apb_pwdata}, 32'd0);
        chk({tag, "_paddr_pstrb_pprot_pwrite"},
            32'({bus.m_apb_paddr, bus.m_apb_pstrb, bus.m_apb_pprot, bus.m_apb_pwrite}), 32'd0);
    endtask

    task automatic chk_payload(input string tag, input logic [3:0] ea, input logic ew,
                               input logic [31:0] ed, input logic [3:0] es, input logic [2:0] ep);
        chk({tag, "_paddr"}, 32'(bus.m_apb_paddr), 32'(ea));
        chk1({tag, "_pwrite"}, bus.m_apb_pwrite, ew);
        chk({tag, "_pwdata"}, bus.m_apb_pwdata, ed);
        chk({tag, "_pstrb"}, 32'(bus.m_apb_pstrb), 32'(es));
        chk({tag, "_pprot"}, 32'(bus.m_apb_pprot), 32'(ep));
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    // waits = ACCESS cycles the slave keeps pready low before raising it.
    task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input logic serr, input logic [31:0] rd, input int rdly,
                           input logic hold_next);
        logic [3:0]  e_addr;
        logic [31:0] e_wdata, e_rdata;
        logic [3:0]  e_strb;
        logic        e_to, e_err;
        int          access_len;

        // Reference model of one transfer.
        e_addr     = addr & 4'hC;
        e_wdata    = wr ? wd : 32'd0;
        e_strb     = wr ? st : 4'd0;
        e_to       = (TMO != 0) && (waits >= TMO);
        access_len = e_to ? TMO : waits + 1;
        e_err      = e_to ? 1'b1 : serr;
        e_rdata    = (e_to || wr) ? 32'd0 : rd;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_strb  = st;
        bus.cmd_prot  = pr;
        for (int k = 0; k < 20 && bus.cmd_ready !== 1'b1; k++) @(negedge clk);
        chk1("cmd_ready_wait", bus.cmd_ready, 1'b1);

        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk1("setup_psel", bus.m_apb_psel, 1'b1);
        chk1("setup_penable", bus.m_apb_penable, 1'b0);
        chk1("setup_cmd_ready", bus.cmd_ready, 1'b0);
        chk_payload("setup", e_addr, wr, e_wdata, e_strb, pr);

        for (int n = 1; n <= access_len; n++) begin
            @(negedge clk);
            chk1("access_psel", bus.m_apb_psel, 1'b1);
            chk1("access_penable", bus.m_apb_penable, 1'b1);
            chk1("access_rsp_valid", bus.rsp_valid, 1'b0);
            chk_payload("access", e_addr, wr, e_wdata, e_strb, pr);
            bus.m_apb_pready  = (n == waits + 1);
            bus.m_apb_prdata  = (n == waits + 1) ? rd : $urandom;
            bus.m_apb_pslverr = (n == waits + 1) ? serr : 1'($urandom);
        end

        @(negedge clk);
        bus.m_apb_pready  = 1'b0;
        bus.m_apb_pslverr = 1'b0;
        bus.m_apb_prdata  = 32'd0;
        chk1("resp_valid", bus.rsp_valid, 1'b1);
        chk_idle_apb("resp");
        chk("resp_rdata", bus.rsp_rdata, e_rdata);
        chk1("resp_err", bus.rsp_err, e_err);
        chk1("resp_timeout", bus.rsp_timeout, e_to);
        if (hold_next) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = 4'($urandom);
        end

        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk1("hold_valid", bus.rsp_valid, 1'b1);
            chk1("hold_cmd_ready", bus.cmd_ready, 1'b0);
            chk1("hold_psel", bus.m_apb_psel, 1'b0);
            chk("hold_rdata", bus.rsp_rdata, e_rdata);
            chk1("hold_err", bus.rsp_err, e_err);
            chk1("hold_timeout", bus.rsp_timeout, e_to);
        end

        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk1("done_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("done_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("done_psel", bus.m_apb_psel, 1'b0);
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_addr      = '0;
        bus.cmd_wdata     = '0;
        bus.cmd_strb      = '0;
        bus.cmd_prot      = '0;
        bus.rsp_ready     = 1'b0;
        bus.m_apb_pready  = 1'b0;
        bus.m_apb_prdata  = '0;
        bus.m_apb_pslverr = 1'b0;

        repeat (2) @(negedge clk);
        chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk_idle_apb("rst");
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_release_cmd_ready", bus.cmd_ready, 1'b1);

        // Write, no wait states.
        run_txn(1'b1, 4'h4, 32'h0000_00A5, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        // Read with three wait states, unaligned address.
        run_txn(1'b0, 4'h6, 32'h1234_5678, 4'hF, 3'd2, 3, 1'b0, 32'h0000_005A, 0, 1'b0);
        // Slave error.
        run_txn(1'b1, 4'h8, 32'hCAFE_F00D, 4'h3, 3'd1, 1, 1'b1, 32'h0, 1, 1'b0);
        // Timeout, then pready on the final allowed ACCESS cycle.
        run_txn(1'b0, 4'hC, 32'h0, 4'h0, 3'd5, 40, 1'b0, 32'h1111_2222, 0, 1'b0);
        run_txn(1'b0, 4'hC, 32'h0, 4'h0, 3'd5, TMO - 1, 1'b0, 32'h3333_4444, 0, 1'b0);
        // Response backpressure with a second command already waiting.
        run_txn(1'b0, 4'h0, 32'h0, 4'h0, 3'd7, 2, 1'b0, 32'h5555_6666, 5, 1'b1);
        run_txn(1'b1, 4'hB, 32'h7777_8888, 4'h9, 3'd3, 0, 1'b0, 32'h0, 0, 1'b0);

        // Reset in the middle of ACCESS drops the transfer.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h8;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk1("pre_rst_penable", bus.m_apb_penable, 1'b1);
        rst = 1'b0;
        #1;
        chk1("arst_psel", bus.m_apb_psel, 1'b0);
        chk1("arst_penable", bus.m_apb_penable, 1'b0);
        chk1("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("arst_cmd_ready", bus.cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk1("arst_release_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        chk1("arst_after_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("arst_after_rsp_valid", bus.rsp_valid, 1'b0);
        run_txn(1'b0, 4'h0, 32'h0, 4'h0, 3'd0, 1, 1'b0, 32'hA5A5_0F0F, 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            int r;
            int w;
            r = int'($urandom_range(0, 9));
            w = (r < 7) ? r % 3 : int'($urandom_range(TMO - 2, TMO + 2));
            run_txn(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 3'($urandom), w,
                    1'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
